// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed 7-segment scan controller with frame-aligned staging buffer
// Optional macro SEG7_LEADING_ZERO_BLANK_EN enables leading-zero digit suppression.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [3:0]              dec_digit_out,
  input  logic [6:0]              dec_segments_in,
  output logic [6:0]              segments_out,
  output logic [NUM_DIGITS-1:0]   digit_en_out,
  output logic                    frame_start
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW      = 4 * NUM_DIGITS;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                show_entry, show_exit, boundary;
  logic [VW-1:0]       display_reg, staging;
  logic                staging_full;
  logic [NUM_DIGITS-1:0] onehot;
  logic                suppress;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    idx_nxt    = idx;
    show_entry = 1'b0;
    show_exit  = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_nxt  = ST_SHOW;
          cnt_nxt    = '0;
          show_entry = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          show_exit = 1'b1;
          idx_nxt   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame boundary: first blank cycle of digit 0; gated so nothing pulses while held in reset.
  assign boundary    = (state == ST_BLANK) && (idx == '0) && (cnt == '0);
  assign frame_start = resetn && boundary;
  assign value_ready = resetn && !staging_full;

  always_comb begin
    dec_digit_out = 4'd0;
    onehot        = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        dec_digit_out = display_reg[4*k +: 4];
        onehot[k]     = 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  all_zero;

  // lz[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    suppress = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (display_reg[4*k +: 4] == 4'd0);
      lz[k]    = all_zero;
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) suppress = lz[k];
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      display_reg  <= '0;
      staging      <= '0;
      staging_full <= 1'b0;
    end else if (boundary && staging_full) begin
      display_reg  <= staging;
      staging_full <= 1'b0;
    end else if (value_valid && value_ready) begin
      staging      <= value_in;
      staging_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      segments_out <= '0;
      digit_en_out <= '0;
    end else if (show_entry) begin
      segments_out <= suppress ? 7'd0 : dec_segments_in;
      digit_en_out <= suppress ? '0 : onehot;
    end else if (show_exit) begin
      segments_out <= '0;
      digit_en_out <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - testbench for seg7_scan_controller (4 digits, SCAN_DIV=4, BLANK_CYCLES=2)
module tb_seg7_scan_controller;

  logic        clk;
  logic        resetn;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  dec_digit_out;
  logic [6:0]  dec_segments_in;
  logic [6:0]  segments_out;
  logic [3:0]  digit_en_out;
  logic        frame_start;

  seg7_scan_controller #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .value_in       (value_in),
    .value_valid    (value_valid),
    .value_ready    (value_ready),
    .dec_digit_out  (dec_digit_out),
    .dec_segments_in(dec_segments_in),
    .segments_out   (segments_out),
    .digit_en_out   (digit_en_out),
    .frame_start    (frame_start)
  );

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign dec_segments_in = hex2seg(dec_digit_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic [27:0] segs;   // {d3,d2,d1,d0}, 7 bits each
    logic [3:0]  mask;   // digits expected lit
  } rec_t;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] M_0000 = 4'b0001;
  localparam logic [3:0] M_0050 = 4'b0011;
  localparam logic [3:0] M_0706 = 4'b0111;
`else
  localparam logic [3:0] M_0000 = 4'b1111;
  localparam logic [3:0] M_0050 = 4'b1111;
  localparam logic [3:0] M_0706 = 4'b1111;
`endif

  rec_t vec [7];
  rec_t cur;
  rec_t exp_q [$];
  rec_t stim_q [$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  function automatic rec_t mk(input logic [15:0] w, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] m);
    rec_t r;
    r.word = w;
    r.segs = {s3, s2, s1, s0};
    r.mask = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Check one cycle against the frame timing model, then drive the handshake and advance.
  task automatic run_cycle();
    int         p, d, ph;
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_ready;
    p  = cyc % 24;
    d  = p / 6;
    ph = p % 6;
    exp_ready = (exp_q.size() == 0);
    if (p == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
    exp_en  = (ph >= 2 && cur.mask[d]) ? 4'(1 << d) : 4'd0;
    exp_seg = (exp_en != 4'd0) ? cur.segs[7*d +: 7] : 7'd0;
    chk("segments", 32'(segments_out), 32'(exp_seg));
    chk("digit_en", 32'(digit_en_out), 32'(exp_en));
    chk("frame_start", 32'(frame_start), 32'(p == 0));
    chk("ready", 32'(value_ready), 32'(exp_ready));
    if (stim_q.size() > 0) begin
      value_valid = 1'b1;
      value_in    = stim_q[0].word;
      if (exp_ready) exp_q.push_back(stim_q.pop_front());
    end else begin
      value_valid = 1'b0;
      value_in    = 16'($urandom);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    vec[0] = mk(16'h0000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, M_0000);
    vec[1] = mk(16'h1234, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b1111);
    vec[2] = mk(16'hABCD, 7'h77, 7'h7C, 7'h39, 7'h5E, 4'b1111);
    vec[3] = mk(16'h0050, 7'h3F, 7'h3F, 7'h6D, 7'h3F, M_0050);
    vec[4] = mk(16'h0000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, M_0000);
    vec[5] = mk(16'h89EF, 7'h7F, 7'h6F, 7'h79, 7'h71, 4'b1111);
    vec[6] = mk(16'h0706, 7'h3F, 7'h07, 7'h3F, 7'h7D, M_0706);
    cur = vec[0];

    resetn      = 1'b0;
    value_valid = 1'b0;
    value_in    = 16'h0;
    repeat (3) begin
      tick();
      chk("rst_ready", 32'(value_ready), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_segments", 32'(segments_out), 32'd0);
      chk("rst_digit_en", 32'(digit_en_out), 32'd0);
    end
    resetn = 1'b1;
    #1;
    cyc = 0;

    while (cyc < 72) begin
      if (cyc >= 2 && cyc <= 5) begin
        chk("first_show_en", 32'(digit_en_out), 32'h1);
        chk("first_show_seg", 32'(segments_out), 32'h3F);
      end
      if (cyc == 6) chk("first_blank_en", 32'(digit_en_out), 32'h0);
      if (cyc == 10) begin
        stim_q.push_back(vec[1]);
        stim_q.push_back(vec[2]);
      end
      if (cyc == 11) chk("ready_drop", 32'(value_ready), 32'd0);
      if (cyc == 24) chk("boundary_pulse", 32'(frame_start), 32'd1);
      if (cyc == 25) chk("ready_rise", 32'(value_ready), 32'd1);
      run_cycle();
    end

    for (int i = 3; i < 7; i++) begin
      stim_q.push_back(vec[i]);
      repeat (48) run_cycle();
    end

    // Reset for one cycle during digit-2 SHOW with a word waiting in staging.
    stim_q.push_back(vec[5]);
    while (cyc % 24 != 15) run_cycle();
    chk("pre_reset_en", 32'(digit_en_out), 32'h4);
    value_valid = 1'b0;
    resetn      = 1'b0;
    tick();
    chk("midrst_segments", 32'(segments_out), 32'd0);
    chk("midrst_digit_en", 32'(digit_en_out), 32'd0);
    chk("midrst_ready", 32'(value_ready), 32'd0);
    resetn = 1'b1;
    #1;
    cyc = 0;
    exp_q.delete();
    stim_q.delete();
    cur = vec[0];
    repeat (48) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
